// File: rtl/i2c_master_bit_engine.sv
// -----------------------------------------------------------------------------
// i2c_master_bit_engine
//
// I2C master bit controller. Each accepted command executes one bus condition
// (START / repeated START, STOP) or one data bit (WRITE, READ) on open-drain
// SCL/SDA. Every command runs through four quarter-bit phases (A..D). Each
// phase lasts PRESCALE+1 system clocks unless the slave stretches SCL.
//
// Handshake: a command transfers on a rising edge where i_cmd_valid=1,
// o_cmd_ready=1 and i_cmd is a legal code. o_cmd_ready is high only in IDLE.
// Illegal codes are ignored. The requester may hold i_cmd_valid while
// o_cmd_ready is low, and the command is taken once the engine returns to IDLE.
//
// Ports
//   i_clk_master  system clock (rising edge)
//   i_reset_n     asynchronous active-low reset
//   i_cmd         001 START, 010 WRITE, 011 READ, 100 STOP
//   i_cmd_valid   command request
//   o_cmd_ready   engine idle; can accept a command
//   i_data_in     bit to write (sampled at acceptance)
//   o_data_out    last bit read
//   o_done        one-cycle pulse at command completion or abort
//   o_arb_lost    one-cycle pulse with o_done on arbitration loss
//   o_busy        a command is executing
//   o_scl_oe      1 = pull SCL low
//   i_scl         SCL pad level
//   o_sda_oe      1 = pull SDA low
//   i_sda         SDA pad level
//   o_dbg_state   current FSM state encoding (debug observation only)
// -----------------------------------------------------------------------------
module i2c_master_bit_engine #(
  parameter int PRESCALE = 124,
  parameter int CNT_W    = 16
) (
  input  logic       i_clk_master,
  input  logic       i_reset_n,
  input  logic [2:0] i_cmd,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_data_in,
  output logic       o_data_out,
  output logic       o_done,
  output logic       o_arb_lost,
  output logic       o_busy,
  output logic       o_scl_oe,
  input  logic       i_scl,
  output logic       o_sda_oe,
  input  logic       i_sda,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b011;
  localparam logic [2:0] CMD_STOP  = 3'b100;

  localparam logic [CNT_W-1:0] RELOAD = PRESCALE[CNT_W-1:0];

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH_A = 3'd1,
    ST_PH_B = 3'd2,
    ST_PH_C = 3'd3,
    ST_PH_D = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       cmd_q;
  logic             bit_q;
  logic             scl_oe_q;
  logic             sda_oe_q;
  logic             data_out_q;
  logic             done_q;
  logic             arb_lost_q;

  // Two-flop synchronisers. They reset to 1 because an idle bus floats high.
  logic scl_s1_q, scl_s2_q;
  logic sda_s1_q, sda_s2_q;

  always_ff @(posedge i_clk_master or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= i_scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= i_sda;
      sda_s2_q <= sda_s1_q;
    end
  end

  // Line drive {scl_oe, sda_oe} for a given command, phase and write bit.
  // START leaves SCL untouched in phase A. This lets the same sequence serve
  // as an idle START (SCL released) and as a repeated START after a bit
  // (SCL already low).
  function automatic logic [1:0] drive(input logic [2:0] cmd, input logic b,
                                       input state_t ph, input logic cur_scl);
    logic scl_v;
    logic sda_v;
    scl_v = cur_scl;
    sda_v = 1'b0;
    case (cmd)
      CMD_START: begin
        sda_v = (ph == ST_PH_C) || (ph == ST_PH_D);
        case (ph)
          ST_PH_A: scl_v = cur_scl;
          ST_PH_D: scl_v = 1'b1;
          default: scl_v = 1'b0;
        endcase
      end
      CMD_STOP: begin
        sda_v = (ph == ST_PH_A) || (ph == ST_PH_B);
        scl_v = (ph == ST_PH_A);
      end
      CMD_WRITE: begin
        sda_v = ~b;
        scl_v = (ph == ST_PH_A) || (ph == ST_PH_D);
      end
      default: begin // READ
        sda_v = 1'b0;
        scl_v = (ph == ST_PH_A) || (ph == ST_PH_D);
      end
    endcase
    return {scl_v, sda_v};
  endfunction

  logic   cmd_legal;
  logic   stretch;
  logic   arb_hit;
  state_t next_phase;

  always_comb begin
    cmd_legal = (i_cmd == CMD_START) || (i_cmd == CMD_WRITE) ||
                (i_cmd == CMD_READ)  || (i_cmd == CMD_STOP);
    // A slave holds SCL low while we have released it, so the phase freezes.
    stretch   = !scl_oe_q && !scl_s2_q;
    // We released SDA for a 1 bit, but another master pulled it low.
    arb_hit   = (cmd_q == CMD_WRITE) && bit_q && !sda_s2_q;
    case (state_q)
      ST_PH_A: next_phase = ST_PH_B;
      ST_PH_B: next_phase = ST_PH_C;
      ST_PH_C: next_phase = ST_PH_D;
      default: next_phase = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_master or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmd_q      <= 3'b000;
      bit_q      <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      data_out_q <= 1'b0;
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (i_cmd_valid && cmd_legal) begin
          cmd_q                <= i_cmd;
          bit_q                <= i_data_in;
          state_q              <= ST_PH_A;
          cnt_q                <= RELOAD;
          {scl_oe_q, sda_oe_q} <= drive(i_cmd, i_data_in, ST_PH_A, scl_oe_q);
        end
      end else if (!stretch) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          // Last clock of the current phase.
          if (state_q == ST_PH_B && cmd_q == CMD_READ) begin
            data_out_q <= sda_s2_q;
          end
          if (state_q == ST_PH_B && arb_hit) begin
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            state_q    <= ST_IDLE;
            done_q     <= 1'b1;
            arb_lost_q <= 1'b1;
          end else if (next_phase == ST_IDLE) begin
            // Line drive is held through IDLE until the next command.
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q              <= next_phase;
            cnt_q                <= RELOAD;
            {scl_oe_q, sda_oe_q} <= drive(cmd_q, bit_q, next_phase, scl_oe_q);
          end
        end
      end
    end
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_scl_oe    = scl_oe_q;
  assign o_sda_oe    = sda_oe_q;
  assign o_data_out  = data_out_q;
  assign o_done      = done_q;
  assign o_arb_lost  = arb_lost_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_bit_engine
//
// Directed bench for i2c_master_bit_engine with PRESCALE=3, which gives
// 4 clocks per phase. The pads are driven directly by the bench as plain
// levels (idle high), so SCL stretching and SDA contention occur only where a
// test forces them.
// Offsets count rising edges after the acceptance edge. Samples are taken 1 ns
// after each edge. Phase p occupies offsets 4p..4p+3, and a normal command
// reports o_done at offset 16.
// -----------------------------------------------------------------------------
module tb_i2c_master_bit_engine;

  localparam int PRESCALE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       data_in;
  logic       data_out;
  logic       done;
  logic       arb_lost;
  logic       busy;
  logic       scl_oe;
  logic       scl_pad;
  logic       sda_oe;
  logic       sda_pad;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  i2c_master_bit_engine #(.PRESCALE(PRESCALE), .CNT_W(16)) dut (
    .i_clk_master (clk),
    .i_reset_n    (rst_n),
    .i_cmd        (cmd),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_data_in    (data_in),
    .o_data_out   (data_out),
    .o_done       (done),
    .o_arb_lost   (arb_lost),
    .o_busy       (busy),
    .o_scl_oe     (scl_oe),
    .i_scl        (scl_pad),
    .o_sda_oe     (sda_oe),
    .i_sda        (sda_pad),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Presents a command, confirms it is taken on the next edge, then follows
  // it to o_done. The SCL/SDA drive is sampled once inside each phase as
  // vec[phase]. When stretch_len > 0, the SCL pad is held low for stretch_len
  // clocks starting at the first clock of phase B.
  task automatic run_cmd(input string name, input logic [2:0] c, input logic b,
                         input int stretch_len, input int exp_lat, input logic exp_arb,
                         input logic chk_vec, input logic [3:0] exp_scl,
                         input logic [3:0] exp_sda);
    logic [3:0] scl_v;
    logic [3:0] sda_v;
    int k;
    int lat;
    scl_v = 4'b0;
    sda_v = 4'b0;
    cmd       = c;
    data_in   = b;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    check({name, "_accept"}, {31'b0, busy}, 32'd1);
    cmd_valid = 1'b0;
    k   = 0;
    lat = -1;
    while (k < 200) begin
      if ((k % 4) == 1 && k < 16) begin
        scl_v[k/4] = scl_oe;
        sda_v[k/4] = sda_oe;
      end
      if (stretch_len > 0 && k == 4) scl_pad = 1'b0;
      if (stretch_len > 0 && k == 4 + stretch_len) scl_pad = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    scl_pad = 1'b1;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_arb_lost"}, {31'b0, arb_lost}, {31'b0, exp_arb});
    if (chk_vec) begin
      check({name, "_scl_seq"}, {28'b0, scl_v}, {28'b0, exp_scl});
      check({name, "_sda_seq"}, {28'b0, sda_v}, {28'b0, exp_sda});
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_done;
    logic seen_busy;
    rst_n     = 1'b0;
    cmd       = 3'b000;
    cmd_valid = 1'b0;
    data_in   = 1'b0;
    scl_pad   = 1'b1;
    sda_pad   = 1'b1;

    // Reset values
    idle_cycles(3);
    check("rst_scl_oe",   {31'b0, scl_oe},    32'd0);
    check("rst_sda_oe",   {31'b0, sda_oe},    32'd0);
    check("rst_data_out", {31'b0, data_out},  32'd0);
    check("rst_done",     {31'b0, done},      32'd0);
    check("rst_arb_lost", {31'b0, arb_lost},  32'd0);
    check("rst_busy",     {31'b0, busy},      32'd0);
    check("rst_ready",    {31'b0, cmd_ready}, 32'd1);

    // Nothing happens while no request is made
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
      seen_busy |= busy;
    end
    check("idle_no_done", {31'b0, seen_done}, 32'd0);
    check("idle_no_busy", {31'b0, seen_busy}, 32'd0);

    // START from idle: SDA rel/rel/low/low, SCL unchanged(rel)/rel/rel/low.
    run_cmd("start", 3'b001, 1'b0, 0, 16, 1'b0, 1'b1, 4'b1000, 4'b1100);
    // WRITE(0) taken in START's done cycle: SDA low throughout, SCL low/rel/rel/low.
    run_cmd("wr0", 3'b010, 1'b0, 0, 16, 1'b0, 1'b1, 4'b1001, 4'b1111);
    check("wr0_data_out", {31'b0, data_out}, 32'd0);
    idle_cycles(2);

    // READ with SDA high, then low; SDA never driven.
    sda_pad = 1'b1;
    run_cmd("rd1", 3'b011, 1'b0, 0, 16, 1'b0, 1'b1, 4'b1001, 4'b0000);
    check("rd1_data_out", {31'b0, data_out}, 32'd1);
    sda_pad = 1'b0;
    idle_cycles(3);
    run_cmd("rd0", 3'b011, 1'b0, 0, 16, 1'b0, 1'b1, 4'b1001, 4'b0000);
    check("rd0_data_out", {31'b0, data_out}, 32'd0);
    sda_pad = 1'b1;
    idle_cycles(3);

    // WRITE(1) with SCL held low for 20 clocks from the start of phase B.
    // The synchroniser lets the first 2 of those clocks count. The phase then
    // freezes for 20 edges: 18 low clocks seen plus 2 more while the released
    // level propagates. Latency is therefore 16 + 20 = 36. Phase C starts at
    // offset 28, so all three later samples fall in phase B (SCL released).
    run_cmd("wr1_stretch", 3'b010, 1'b1, 20, 36, 1'b0, 1'b1, 4'b0001, 4'b0000);
    check("wr1_stretch_data_out", {31'b0, data_out}, 32'd0);
    idle_cycles(3);

    // Arbitration loss: WRITE(1) with SDA pulled low by someone else.
    // The last phase-B clock is offset 7, so o_done appears at offset 8.
    sda_pad = 1'b0;
    idle_cycles(3);
    run_cmd("arb", 3'b010, 1'b1, 0, 8, 1'b1, 1'b0, 4'b0000, 4'b0000);
    check("arb_scl_oe", {31'b0, scl_oe}, 32'd0);
    check("arb_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("arb_busy",   {31'b0, busy},   32'd0);
    idle_cycles(1);
    check("arb_done_pulse", {31'b0, done}, 32'd0);
    sda_pad = 1'b1;
    idle_cycles(3);

    // Illegal command code is dropped.
    cmd       = 3'b111;
    cmd_valid = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
      seen_busy |= busy;
    end
    cmd_valid = 1'b0;
    check("illegal_no_done", {31'b0, seen_done}, 32'd0);
    check("illegal_no_busy", {31'b0, seen_busy}, 32'd0);

    // Reset in the middle of a STOP (phase B: SDA held low, SCL released).
    cmd       = 3'b100;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    idle_cycles(5);
    check("stop_mid_sda_oe", {31'b0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_scl_oe", {31'b0, scl_oe}, 32'd0);
    check("midrst_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("midrst_busy",   {31'b0, busy},   32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    check("midrst_no_done", {31'b0, seen_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
